actigrad: RTL and testbench

ACTIGRAD -- requirements
Module: actigrad

---
 rtl/actigrad_pkg.sv | 19 +
 rtl/serial_mul.sv | 45 ++++
 rtl/actigrad.sv | 106 ++++++++++
 tb/tb_actigrad.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/actigrad_pkg.sv
// Shared widths, constants and state encoding for the actigrad sigmoid-gradient block.
package actigrad_pkg;

    localparam int unsigned Y_W   = 16;
    localparam int unsigned E_W   = 24;
    localparam int unsigned P_W   = E_W + Y_W;
    localparam int unsigned ITER  = 16;
    localparam int unsigned CNT_W = $clog2(ITER);

    localparam logic [Y_W-1:0] ONE_Y = 16'h8000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul1 = 2'd1,
        StMul2 = 2'd2,
        StDone = 2'd3
    } state_t;

endpackage

// File: rtl/serial_mul.sv
// Radix-2 shift-add multiplier: signed 24-bit multiplicand by unsigned 16-bit multiplier,
// one multiplier bit per enabled cycle. The product output is the running sum including
// the current partial term, so on the done cycle it already holds the full 40-bit result.
module serial_mul
    import actigrad_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en,
    input  logic [E_W-1:0]   mcand,
    input  logic [Y_W-1:0]   mplier,
    output logic             done,
    output logic [P_W-1:0]   product
);

    logic [P_W-1:0]   acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [P_W-1:0]   mcand_ext;
    logic [P_W-1:0]   partial;

    // Partial product for the current multiplier bit and the running sum.
    always_comb begin
        mcand_ext = {{(P_W-E_W){mcand[E_W-1]}}, mcand};
        partial   = mplier[cnt_q] ? (mcand_ext << cnt_q) : '0;
        product   = acc_q + partial;
        done      = en && (cnt_q == CNT_W'(ITER - 1));
    end

    // Accumulate while enabled; clear on start and after the last iteration so the
    // next multiply begins from zero without a separate setup cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (start || done) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (en) begin
            acc_q <= product;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/actigrad.sv
// Sigmoid backprop gradient: grad = err * y * (1 - y), computed with two sequential
// 16-cycle multiplies on a single shared serial multiplier.
module actigrad
    import actigrad_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Y_W-1:0] y_in,
    input  logic [E_W-1:0] err_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [E_W-1:0] grad_out
);

    state_t         state_q, state_d;
    logic [Y_W-1:0] y_q;
    logic [E_W-1:0] err_q;
    logic [Y_W-1:0] d15_q;
    logic [E_W-1:0] grad_q;
    logic [Y_W-1:0] om;

    logic           mul_start;
    logic           mul_en;
    logic           mul_done;
    logic [E_W-1:0] mul_mcand;
    logic [Y_W-1:0] mul_mplier;
    logic [P_W-1:0] mul_product;
    logic           unused_product_bits;

    serial_mul u_serial_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .en      (mul_en),
        .mcand   (mul_mcand),
        .mplier  (mul_mplier),
        .done    (mul_done),
        .product (mul_product)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each multiply phase ends on the multiplier's last iteration.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (in_valid) state_d = StMul1;
            StMul1: if (mul_done) state_d = StMul2;
            StMul2: if (mul_done) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshakes and multiplier operand routing.
    always_comb begin
        om         = ONE_Y - y_q;
        in_ready   = (state_q == StIdle);
        out_valid  = (state_q == StDone);
        mul_start  = in_valid && (state_q == StIdle);
        mul_en     = (state_q == StMul1) || (state_q == StMul2);
        mul_mcand  = err_q;
        mul_mplier = d15_q;
        if (state_q == StMul1) begin
            mul_mcand  = {{(E_W-Y_W){1'b0}}, y_q};
            mul_mplier = om;
        end
    end

    // Operand capture, intermediate d15 and the final gradient register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q    <= '0;
            err_q  <= '0;
            d15_q  <= '0;
            grad_q <= '0;
        end else begin
            if (mul_start) begin
                // y >= 1.0 is clamped to exactly 1.0 so the derivative term is zero.
                y_q   <= y_in[Y_W-1] ? ONE_Y : y_in;
                err_q <= err_in;
            end
            if (mul_done && state_q == StMul1) begin
                d15_q <= mul_product[30:15];
            end
            if (mul_done && state_q == StMul2) begin
                grad_q <= mul_product[38:15];
            end
        end
    end

    assign grad_out = grad_q;

    // Bit 39 is pure sign extension and bits below 15 are truncated away.
    assign unused_product_bits = ^{mul_product[P_W-1], mul_product[14:0]};

endmodule

// File: tb/tb_actigrad.sv
// Scoreboard bench for actigrad: stimulus pushes expected gradients, a monitor pops
// and compares whenever out_valid presents a new result.
module tb_actigrad;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] y_in;
    logic [23:0] err_in;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] grad_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [23:0] exp_q[$];
    int          t_q[$];
    logic        holding = 1'b0;
    logic [23:0] held;
    logic        auto_ready = 1'b1;

    actigrad dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .err_in    (err_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grad_out  (grad_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: grad = floor(err * d15 / 2^15) with d15 = floor(y*(1-y) / 2^15).
    function automatic logic [23:0] model(input logic [15:0] y, input logic [23:0] err);
        longint yy, om, d15, e, p, r;
        yy  = y[15] ? 64'd32768 : longint'(y);
        om  = 32768 - yy;
        d15 = (yy * om) / 32768;
        e   = longint'($signed(err));
        p   = e * d15;
        r   = p >>> 15;
        return r[23:0];
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic send(input logic [15:0] y, input logic [23:0] e, input logic [23:0] exp);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        y_in     = y;
        err_in   = e;
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        t_q.push_back(cyc);
        in_valid = 1'b0;
    endtask

    // Random downstream readiness, disabled for directed backpressure.
    always @(posedge clk) begin
        if (auto_ready) begin
            #1;
            if (auto_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: new result on first valid sample, stability while held off.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!holding) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got grad %h expected none", grad_out);
                end else begin
                    logic [23:0] e;
                    int t;
                    e = exp_q.pop_front();
                    t = t_q.pop_front();
                    check("grad", grad_out, e);
                    total++;
                    if (cyc - t != 32) begin
                        bad++;
                        $display("FAIL latency: got %0d expected 32", cyc - t);
                    end
                end
                held = grad_out;
            end else begin
                check("grad_hold", grad_out, held);
            end
            holding = !out_ready;
        end else begin
            holding = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        y_in      = '0;
        err_in    = '0;
        out_ready = 1'b1;
        #23;
        check("reset_in_ready", 24'(in_ready), 24'd1);
        check("reset_out_valid", 24'(out_valid), 24'd0);
        check("reset_grad", grad_out, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operating points.
        send(16'h4000, 24'h100000, 24'h040000);
        send(16'h4000, 24'hF00000, 24'hFC0000);
        send(16'h6000, 24'h100000, 24'h030000);
        send(16'h0000, 24'h7FFFFF, 24'h000000);
        send(16'hFFFF, 24'h123456, 24'h000000);

        // Backpressure: hold off for 10 cycles in DONE, new inputs must be ignored.
        begin
            int n = 0;
            @(negedge clk);
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            auto_ready = 1'b0;
            out_ready  = 1'b0;
            send(16'h2000, 24'h0ABCDE, model(16'h2000, 24'h0ABCDE));
            n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("bp_reached_done", 24'(out_valid), 24'd1);
            repeat (10) begin
                @(posedge clk);
                #2;
                in_valid = 1'b1;
                y_in     = 16'($urandom);
                err_in   = 24'($urandom);
                @(negedge clk);
                check("bp_in_ready", 24'(in_ready), 24'd0);
                check("bp_out_valid", 24'(out_valid), 24'd1);
            end
            @(posedge clk);
            #2;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("bp_release_in_ready", 24'(in_ready), 24'd1);
            check("bp_release_out_valid", 24'(out_valid), 24'd0);
            auto_ready = 1'b1;
        end

        // Reset during MUL2.
        send(16'h4000, 24'h100000, 24'h040000);
        repeat (22) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 24'(out_valid), 24'd0);
        check("midrst_grad", grad_out, 24'h0);
        check("midrst_in_ready", 24'(in_ready), 24'd1);
        exp_q.delete();
        t_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h4000, 24'h100000, 24'h040000);

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ry;
            logic [23:0] re;
            ry = 16'($urandom);
            re = 24'($urandom);
            if (i % 8 == 0) ry = 16'h8000 - 16'($urandom_range(0, 2));
            send(ry, re, model(ry, re));
        end

        begin
            int n = 0;
            while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
